result_stream_tx: RTL and testbench
===================================

Name: result_stream_tx

Overview:
- Consumer end of the packed matrix-product result bus.
- Captures one 10x10 packed result word of 3000 bits in a single handshake, then transmits it element by element over a valid/ready stream in row-major order.
- Sits between the combinational matrix multiply stage and downstream serial logic (classifier / output FIFO).
- Frees the multiplier inputs as soon as the word is latched.

Parameters:
- ROWS, 10, result rows
- COLS, 10, result columns
- DW, 30, element width in bits
- Derived, not overridable: TOTAL = ROWS*COLS, BUS_W = TOTAL*DW (3000), IDX_W = clog2(TOTAL) (7)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  result_in holds a valid packed result
- load_ready  out  1  block can accept a new packed result
- result_in  in  BUS_W  packed result; element (i,j) at bits [BUS_W-1-DW*(COLS*i+j) -: DW], so (0,0) is at the MSBs
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  downstream accepts the element
- out_data  out  DW  current element
- out_row  out  4  row index i of the current element
- out_col  out  4  column index j of the current element
- out_last  out  1  high with element (ROWS-1, COLS-1)
- busy  out  1  high while in STREAM

Behaviour:
- One clock domain (clk). Synchronous active-high reset (rst).
- Reset values: state=IDLE, load_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0. Shadow register and index cleared.
- Two-state FSM, IDLE and STREAM.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid&&load_ready: latch result_in into the BUS_W shadow register, set idx=0, row=0, col=0, go to STREAM.
  - out_valid rises on the next cycle (1-cycle load-to-first-element latency).
- STREAM:
  - load_ready=0, out_valid=1, busy=1.
  - out_data = shadow element idx, taken from a shift-left-by-DW of the shadow register (MSB slice), not a wide mux.
  - Advance on out_valid&&out_ready: shift shadow, idx+1, col+1; when col wraps COLS-1 -> 0, row+1.
  - out_data, out_row, out_col and out_last are stable while out_valid && !out_ready (AXI-style hold).
- Last element: out_last=1 when idx==TOTAL-1. Its handshake returns the FSM to IDLE; load_ready=1 the following cycle.
- No load is accepted in the same cycle as the last handshake. Minimum period is TOTAL+1 cycles per matrix with out_ready held high.
- load_valid in STREAM is ignored; the source must hold it. result_in changes during STREAM have no effect.
- rst mid-stream: return to IDLE next edge and discard the remaining elements. No out_last is emitted.
- out_ready held low: the FSM stalls indefinitely with no element loss or duplication.
- Arithmetic: counters wrap only via the explicit compare. out_row and out_col never exceed ROWS-1 and COLS-1.

Optional Feature:
- Macro: RESULT_STREAM_ARGMAX_EN.
- Defined:
  - Adds outputs row_argmax (4 bits) and row_argmax_vld (1 bit).
  - Tracks the running maximum of the unsigned elements handshaken in the current row. A tie keeps the earlier column.
  - row_argmax_vld pulses 1 cycle after the handshake of column COLS-1, with row_argmax = winning column.
  - Both outputs reset to 0; the running maximum clears on row start and on rst.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Decomposition:
- Shared package mm_pkg: ROWS, COLS, DW, TOTAL, BUS_W, the element-slice index function, the FSM state enum (ST_IDLE, ST_STREAM).
- The same package also serves the multiply stage.
- One natural sub-module: rc_counter (row/col counter with advance, clear and wrap flags), reusable by a future loader.

Test Plan:
- Reset, then load a word with element k = k+1 (1..100), out_ready=1. Expect:
  - first out_valid 1 cycle after the load handshake
  - out_data sequence 1..100 with (row,col) = (0,0)..(9,9)
  - out_last only on value 100
  - load_ready high 101 cycles after the load.
- Same word, out_ready toggling 1,0,0,1. Expect no element lost or duplicated, and out_data/out_row/out_col held during the low cycles.
- Hold load_valid=1 with new data during STREAM. Expect no capture and load_ready=0; the second word is accepted only after out_last is handshaken.
- Assert rst after element 37 is handshaken. Expect the next cycle: out_valid=0, load_ready=1, busy=0; a new load restarts at (0,0).
- Load a word with element (i,j)=0x3FFFFFFF and all others 0. Expect that value delivered exactly at (i,j) and the other 99 elements equal to 0, confirming slice order.
- With RESULT_STREAM_ARGMAX_EN: row 2 = {5,9,9,1,0,0,0,0,0,0} -> row_argmax=1 pulses once after (2,9); an all-zero row -> row_argmax=0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-product result path.
// Element (i,j) of the packed result bus sits at the MSB end for (0,0),
// walking toward the LSBs in row-major order.
package mm_pkg;

    localparam int ROWS  = 10;
    localparam int COLS  = 10;
    localparam int DW    = 30;
    localparam int TOTAL = ROWS * COLS;
    localparam int BUS_W = TOTAL * DW;
    localparam int IDX_W = $clog2(TOTAL);
    localparam int RC_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // MSB bit position of element (i,j) inside the packed result bus.
    function automatic int elem_msb(input int i, input int j);
        return BUS_W - 1 - DW * (COLS * i + j);
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Row/column position counter for a row-major walk over a ROWS x COLS grid.
// clr returns to (0,0); adv steps one element; col_wrap flags the step that
// leaves the last column. Both counters wrap only through explicit compares.
module rc_counter #(
    parameter int ROWS = 10,
    parameter int COLS = 10,
    parameter int W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         col_wrap
);

    localparam logic [W-1:0] ROW_MAX = W'(ROWS - 1);
    localparam logic [W-1:0] COL_MAX = W'(COLS - 1);

    logic [W-1:0] row_q, row_d;
    logic [W-1:0] col_q, col_d;

    // Next position: clear wins, otherwise step with column-then-row wrap.
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        col_wrap = adv && (col_q == COL_MAX);
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/result_stream_tx.sv
// Captures one packed ROWS x COLS result word in a single handshake and
// streams it out element by element (row-major) on a valid/ready port.
// The word is held in a shadow register that shifts left by DW per accepted
// element, so the current element is always the MSB slice.
// Optional macro RESULT_STREAM_ARGMAX_EN adds a per-row argmax side output.
module result_stream_tx
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [BUS_W-1:0]  result_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [RC_W-1:0]   out_row,
    output logic [RC_W-1:0]   out_col,
    output logic              out_last,
    output logic              busy
`ifdef RESULT_STREAM_ARGMAX_EN
    ,
    output logic [RC_W-1:0]   row_argmax,
    output logic              row_argmax_vld
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);

    state_e             state_q, state_d;
    logic [BUS_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               load_fire;
    logic               adv_fire;
    logic               col_wrap;
    logic               stream_done;

    assign load_fire   = load_valid && load_ready;
    assign adv_fire    = out_valid && out_ready;
    // The final element's handshake is the column wrap at the last index.
    assign stream_done = col_wrap && (idx_q == IDX_LAST);

    rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .W    (RC_W)
    ) u_rc (
        .clk      (clk),
        .rst      (rst),
        .clr      (load_fire),
        .adv      (adv_fire),
        .row      (out_row),
        .col      (out_col),
        .col_wrap (col_wrap)
    );

    // State, shadow word and element index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
        end
    end

    // Next state: load moves to STREAM, the last handshake returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load_fire)   state_d = ST_STREAM;
            ST_STREAM: if (stream_done) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        load_ready = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_STREAM);
        busy       = (state_q == ST_STREAM);
        out_last   = (state_q == ST_STREAM) && (idx_q == IDX_LAST);
        out_data   = shadow_q[BUS_W-1 -: DW];
    end

    // Shadow capture/shift and index stepping; zeros shift in behind the
    // data so the register is empty again once the last element leaves.
    always_comb begin
        shadow_d = shadow_q;
        idx_d    = idx_q;
        if (load_fire) begin
            shadow_d = result_in;
            idx_d    = '0;
        end else if (adv_fire) begin
            shadow_d = {shadow_q[BUS_W-DW-1:0], {DW{1'b0}}};
            idx_d    = stream_done ? '0 : idx_q + 1'b1;
        end
    end

`ifdef RESULT_STREAM_ARGMAX_EN
    logic [DW-1:0]   max_q, max_d;
    logic [RC_W-1:0] arg_q, arg_d;
    logic [RC_W-1:0] row_argmax_q, row_argmax_d;
    logic            row_argmax_vld_q, row_argmax_vld_d;
    logic [DW-1:0]   cand_max;
    logic [RC_W-1:0] cand_arg;

    // Running row maximum; column 0 always seeds it, a tie keeps the older column.
    always_comb begin
        max_d            = max_q;
        arg_d            = arg_q;
        row_argmax_d     = row_argmax_q;
        row_argmax_vld_d = 1'b0;
        cand_max         = max_q;
        cand_arg         = arg_q;
        if (out_col == '0 || out_data > max_q) begin
            cand_max = out_data;
            cand_arg = out_col;
        end
        if (load_fire) begin
            max_d = '0;
            arg_d = '0;
        end else if (adv_fire) begin
            if (col_wrap) begin
                row_argmax_d     = cand_arg;
                row_argmax_vld_d = 1'b1;
                max_d            = '0;
                arg_d            = '0;
            end else begin
                max_d = cand_max;
                arg_d = cand_arg;
            end
        end
    end

    // Argmax tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q            <= '0;
            arg_q            <= '0;
            row_argmax_q     <= '0;
            row_argmax_vld_q <= 1'b0;
        end else begin
            max_q            <= max_d;
            arg_q            <= arg_d;
            row_argmax_q     <= row_argmax_d;
            row_argmax_vld_q <= row_argmax_vld_d;
        end
    end

    assign row_argmax     = row_argmax_q;
    assign row_argmax_vld = row_argmax_vld_q;
`endif

endmodule

// File: tb/tb_result_stream_tx.sv
// Self-checking bench for result_stream_tx: directed sequence of loads and
// drains, expected elements kept as a plain array indexed in stream order.
`timescale 1ns/1ps
module tb_result_stream_tx;

    localparam int R  = 10;
    localparam int C  = 10;
    localparam int W  = 30;
    localparam int N  = R * C;
    localparam int BW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [BW-1:0] result_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [3:0]    out_row;
    logic [3:0]    out_col;
    logic          out_last;
    logic          busy;
`ifdef RESULT_STREAM_ARGMAX_EN
    logic [3:0]    row_argmax;
    logic          row_argmax_vld;
`endif

    int total = 0;
    int bad   = 0;
    int xfer  = 0;

    logic [W-1:0] cur_e [N];
    logic [W-1:0] nxt_e [N];

    always #5 clk = ~clk;

    result_stream_tx dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .result_in  (result_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .busy       (busy)
`ifdef RESULT_STREAM_ARGMAX_EN
        ,
        .row_argmax     (row_argmax),
        .row_argmax_vld (row_argmax_vld)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference argmax: first column holding the largest value of row r.
    function automatic int ref_argmax(input int r);
        int best = 0;
        for (int c = 1; c < C; c++)
            if (cur_e[r*C + c] > cur_e[r*C + best]) best = c;
        return best;
    endfunction

    task automatic pack_next(output logic [BW-1:0] w);
        w = '0;
        for (int k = 0; k < N; k++) w[BW-1-W*k -: W] = nxt_e[k];
    endtask

    task automatic fill_seq();
        for (int k = 0; k < N; k++) nxt_e[k] = W'(k + 1);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < N; k++) nxt_e[k] = W'($urandom);
    endtask

    task automatic fill_onehot(input int i, input int j);
        for (int k = 0; k < N; k++) nxt_e[k] = '0;
        nxt_e[i*C + j] = 30'h3FFFFFFF;
    endtask

    // Present nxt_e as a packed word, wait for acceptance, check first element timing.
    task automatic load_word();
        logic [BW-1:0] w;
        int waited = 0;
        pack_next(w);
        result_in  = w;
        load_valid = 1'b1;
        while (!load_ready && waited < 300) begin
            tick();
            waited++;
        end
        chk("load_ready_wait", load_ready, 1);
        tick();
        load_valid = 1'b0;
        result_in  = ~w;
        cur_e      = nxt_e;
        chk("first_valid", out_valid, 1);
        chk("first_rc", {out_row, out_col}, 8'h00);
    endtask

    // Accept stop_after elements under the given out_ready pattern.
    // mode 0: always ready, 1: pattern 1,0,0,1, 2: random.
    task automatic drain(input int mode, input int stop_after, output int cyc);
        int   k = 0;
        logic rdy;
        logic exp_vld = 1'b0;
        int   exp_arg = 0;
        cyc = 0;
        while (k < stop_after && cyc < 4000) begin
            chk("out_valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("load_ready_stream", load_ready, 0);
            chk("out_data", out_data, cur_e[k]);
            chk("out_rc", {out_row, out_col}, {4'(k / C), 4'(k % C)});
            chk("out_last", out_last, (k == N - 1));
`ifdef RESULT_STREAM_ARGMAX_EN
            chk("argmax_vld", row_argmax_vld, exp_vld);
            if (exp_vld) chk("argmax", row_argmax, 64'(exp_arg));
`endif
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            tick();
            cyc++;
            exp_vld = 1'b0;
            if (rdy) begin
                if (k % C == C - 1) begin
                    exp_vld = 1'b1;
                    exp_arg = ref_argmax(k / C);
                end
                k++;
            end
        end
        out_ready = 1'b0;
        chk("drain_count", k, stop_after);
`ifdef RESULT_STREAM_ARGMAX_EN
        chk("argmax_vld_end", row_argmax_vld, exp_vld);
        if (exp_vld) chk("argmax_end", row_argmax, 64'(exp_arg));
`endif
        if (stop_after == N) begin
            chk("idle_valid", out_valid, 0);
            chk("idle_load_ready", load_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_last", out_last, 0);
            chk("idle_rc", {out_row, out_col}, 8'h00);
        end
        xfer++;
        $display("xfer %0d mode=%0d elems=%0d cycles=%0d", xfer, mode, k, cyc);
    endtask

    initial begin
        int cyc;
        logic [BW-1:0] w2;

        rst        = 1'b1;
        load_valid = 1'b0;
        out_ready  = 1'b0;
        result_in  = '0;
        tick();
        tick();
        chk("rst_load_ready", load_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rc", {out_row, out_col}, 8'h00);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
`ifdef RESULT_STREAM_ARGMAX_EN
        chk("rst_argmax", {row_argmax, row_argmax_vld}, 5'h00);
`endif
        rst = 1'b0;
        tick();

        // Sequential word at full rate: minimum period.
        fill_seq();
        load_word();
        drain(0, N, cyc);
        chk("period", cyc, N);

        // Same word with a 1,0,0,1 ready pattern.
        fill_seq();
        load_word();
        drain(1, N, cyc);

        // load_valid held with a second word during the stream.
        fill_rand();
        load_word();
        fill_rand();
        pack_next(w2);
        result_in  = w2;
        load_valid = 1'b1;
        drain(0, N, cyc);
        load_word();
        drain(2, N, cyc);

        // Reset after 37 handshakes, then a fresh load restarts at (0,0).
        fill_rand();
        load_word();
        out_ready = 1'b1;
        drain(0, 37, cyc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_load_ready", load_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_last", out_last, 0);
`ifdef RESULT_STREAM_ARGMAX_EN
        chk("midrst_argmax", {row_argmax, row_argmax_vld}, 5'h00);
`endif
        fill_rand();
        load_word();
        drain(2, N, cyc);

        // Single non-zero element confirms slice order.
        fill_onehot(0, 0);
        load_word();
        drain(0, N, cyc);
        fill_onehot(R - 1, C - 1);
        load_word();
        drain(2, N, cyc);
        for (int t = 0; t < 2; t++) begin
            fill_onehot(int'($urandom_range(0, R - 1)), int'($urandom_range(0, C - 1)));
            load_word();
            drain(t, N, cyc);
        end

        // Ties and an all-zero row for the row maximum tracking.
        fill_rand();
        for (int c = 0; c < C; c++) begin
            nxt_e[2*C + c] = '0;
            nxt_e[3*C + c] = '0;
        end
        nxt_e[2*C + 0] = 30'd5;
        nxt_e[2*C + 1] = 30'd9;
        nxt_e[2*C + 2] = 30'd9;
        nxt_e[2*C + 3] = 30'd1;
        load_word();
        drain(2, N, cyc);

        // Random words under random backpressure.
        for (int t = 0; t < 3; t++) begin
            fill_rand();
            load_word();
            drain(2, N, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
